// File: rtl/divider_unit_if.sv
// Request/result bundle for the 8-bit restoring divider.
// The requester owns the master side; the divider implements the slave side.
interface divider_unit_if;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider_unit.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, 8 iterations,
// then a single-cycle done pulse.
module divider_unit (
  input  logic           clk,
  input  logic           reset_n,
  divider_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] q_q, q_d;
  logic [7:0] r_q, r_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic       dbz_q, dbz_d;

  logic [8:0] p;
  logic [9:0] diff;
  logic       diff_unused_bit;

  // Bit 8 of a non-negative difference is always zero since P < 2*D there.
  assign diff_unused_bit = diff[8];

  always_comb begin
    p       = {r_q, q_q[7]};
    diff    = {1'b0, p} - {2'b00, d_q};
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d     = bus.dividend;
          r_d     = 8'd0;
          d_d     = bus.divisor;
          cnt_d   = 3'd0;
          dbz_d   = (bus.divisor == 8'd0);
          state_d = CALC;
        end
      end
      CALC: begin
        if (diff[9]) begin
          r_d = p[7:0];
          q_d = {q_q[6:0], 1'b0};
        end else begin
          r_d = diff[7:0];
          q_d = {q_q[6:0], 1'b1};
        end
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      d_q     <= 8'd0;
      cnt_q   <= 3'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: expected results are queued at start
// time and compared when the done pulse appears.
module tb_divider_unit;

  logic clk;
  logic reset_n;

  divider_unit_if bus ();

  divider_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.dbz = (b == 8'd0);
    if (b == 8'd0) begin
      e.q = 8'hFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Presents a request at a negedge; returns #1 after the accepting edge.
  task automatic drive_start(input logic [7:0] a, input logic [7:0] b,
                             input bit push, input bit hold);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) sb_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output bit ok, output int lat);
    ok  = 1'b0;
    lat = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok  = 1'b1;
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    bit   ok;
    int   lat;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    #1;
    tests_run++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    repeat (3) @(negedge clk);
    reset_n      = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd20;
    bus.divisor  = 8'd3;
    sb_q.push_back(model(8'd20, 8'd3));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(ok, lat);
    tests_run++;
    if (!ok || lat != 8) begin
      tests_failed++;
      $display("FAIL first_edge_accept: done ok=%b latency=%0d, want latency 8", ok, lat);
    end
    e = sb_q.pop_front();
    tests_run++;
    if (bus.quotient !== e.q || bus.remainder !== e.r) begin
      tests_failed++;
      $display("FAIL first_op_20_3: got q=%0d r=%0d, want q=%0d r=%0d",
               bus.quotient, bus.remainder, e.q, e.r);
    end
    $display("[TB] reset + 20/3 -> q=%0d r=%0d", bus.quotient, bus.remainder);
  endtask

  task automatic test_basic();
    exp_t e;
    drive_start(8'd100, 8'd7, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      tests_run++;
      if (bus.busy !== (n < 8) || bus.done !== (n == 8)) begin
        tests_failed++;
        $display("FAIL timing_100_7 cycle %0d: got busy=%b done=%b, want busy=%b done=%b",
                 n, bus.busy, bus.done, (n < 8), (n == 8));
      end
      if (n == 8) begin
        e = sb_q.pop_front();
        tests_run++;
        if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
          tests_failed++;
          $display("FAIL result_100_7: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                   bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
        end
      end
    end
    $display("[TB] 100/7 -> q=%0d r=%0d", bus.quotient, bus.remainder);
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'd255, 8'd5, 8'd200, 8'd0};
    logic [7:0] vb [4] = '{8'd1,   8'd9, 8'd0,   8'd0};
    exp_t e;
    bit   ok;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      drive_start(va[i], vb[i], 1'b1, 1'b0);
      wait_done(ok, lat);
      e = sb_q.pop_front();
      tests_run++;
      if (!ok || lat != 8) begin
        tests_failed++;
        $display("FAIL latency_%0d_%0d: ok=%b latency=%0d, want 8", va[i], vb[i], ok, lat);
      end
      tests_run++;
      if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== e.dbz) begin
        tests_failed++;
        $display("FAIL vector_%0d_%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                 va[i], vb[i], bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
      end
      @(negedge clk);
      tests_run++;
      if (bus.div_by_zero !== e.dbz || bus.quotient !== e.q) begin
        tests_failed++;
        $display("FAIL hold_%0d_%0d: got q=%0d dbz=%b in idle, want q=%0d dbz=%b",
                 va[i], vb[i], bus.quotient, bus.div_by_zero, e.q, e.dbz);
      end
      $display("[TB] %0d/%0d -> q=%0d r=%0d dbz=%b", va[i], vb[i],
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    bit   ok;
    int   lat;
    bit   seen_done;
    drive_start(8'd77, 8'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1 || bus.div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: got busy=%b dbz=%b, want busy=1 dbz=1", bus.busy, bus.div_by_zero);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== 19'd0) begin
      tests_failed++;
      $display("FAIL abort_clear: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    tests_run++;
    if (seen_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: got done pulse after abort, want none");
    end
    drive_start(8'd50, 8'd5, 1'b1, 1'b0);
    wait_done(ok, lat);
    e = sb_q.pop_front();
    tests_run++;
    if (!ok || bus.quotient !== e.q || bus.remainder !== e.r) begin
      tests_failed++;
      $display("FAIL after_abort_50_5: ok=%b got q=%0d r=%0d, want q=%0d r=%0d",
               ok, bus.quotient, bus.remainder, e.q, e.r);
    end
    $display("[TB] abort then 50/5 -> q=%0d r=%0d", bus.quotient, bus.remainder);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ok;
    int   lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    sb_q.push_back(model(8'd100, 8'd7));
    @(posedge clk);
    #1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    sb_q.push_back(model(8'd9, 8'd2));
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      if (n == 8) begin
        e = sb_q.pop_front();
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== e.q || bus.remainder !== e.r) begin
          tests_failed++;
          $display("FAIL b2b_first: got done=%b busy=%b q=%0d r=%0d, want done=1 busy=0 q=%0d r=%0d",
                   bus.done, bus.busy, bus.quotient, bus.remainder, e.q, e.r);
        end
      end
      if (n == 9) begin
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'd14) begin
          tests_failed++;
          $display("FAIL b2b_idle_gap: got busy=%b done=%b q=%0d, want busy=0 done=0 q=14",
                   bus.busy, bus.done, bus.quotient);
        end
      end
      if (n == 10) begin
        tests_run++;
        if (bus.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_reload_k10: got busy=%b, want 1", bus.busy);
        end
        bus.start = 1'b0;
      end
    end
    wait_done(ok, lat);
    e = sb_q.pop_front();
    tests_run++;
    if (!ok || lat != 7 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      tests_failed++;
      $display("FAIL b2b_second: ok=%b lat=%0d got q=%0d r=%0d, want lat=7 q=%0d r=%0d",
               ok, lat, bus.quotient, bus.remainder, e.q, e.r);
    end
    $display("[TB] back-to-back second 9/2 -> q=%0d r=%0d", bus.quotient, bus.remainder);
  endtask

  task automatic test_sweep();
    exp_t       e;
    bit         ok;
    int         lat;
    logic [7:0] a, b;
    for (int i = 0; i < 160; i++) begin
      if (i == 0) begin
        a = 8'd0;   b = 8'd1;
      end else if (i == 1) begin
        a = 8'd255; b = 8'd255;
      end else if (i == 2) begin
        a = 8'd1;   b = 8'd255;
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(1, 255));
      end
      drive_start(a, b, 1'b1, 1'b0);
      wait_done(ok, lat);
      e = sb_q.pop_front();
      tests_run++;
      if (!ok || bus.quotient !== e.q || bus.remainder !== e.r || bus.div_by_zero !== 1'b0) begin
        tests_failed++;
        $display("FAIL sweep_%0d_%0d: ok=%b got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                 a, b, ok, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r);
      end
      $display("[TB] sweep %0d/%0d -> q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
